// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes and FSM state encoding for locked_data_memory
// Purpose: request opcode values and controller state type used by the
//          locked data memory and its bench.
// Ports:   none (package)
package mem_pkg;

  localparam logic [1:0] OP_READ       = 2'b00;
  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_LOCK_READ  = 2'b10;
  localparam logic [1:0] OP_COND_WRITE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/be_ram_array.sv
// rtl/be_ram_array.sv - byte-enable word array, synchronous write, combinational read
// Purpose: storage for locked_data_memory. Contents are never reset.
// Ports:
//   clk    in  clock; writes commit on posedge
//   we     in  write enable for this cycle
//   idx    in  word index (shared by read and write)
//   wdata  in  write data
//   be     in  byte enables; only enabled bytes are written
//   rdata  out current contents of word idx (pre-write value during a write cycle)
module be_ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        be,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/locked_data_memory.sv
// rtl/locked_data_memory.sv - single-port data memory with per-word LR/SC lock bits
// Purpose: word-addressed load/store memory with byte-enable writes, a
//          valid/ready request/response handshake (one outstanding request)
//          and one lock bit per word for lock-read / conditional-write atomics.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_op        00 READ, 01 WRITE, 10 LOCK_READ, 11 COND_WRITE
//   req_addr      byte address; low ADDR_LSB bits ignored
//   req_wdata     write data
//   req_be        byte enables for WRITE / COND_WRITE
//   moe           output enable; rsp_rdata reads as 0 when low
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata     read data (old contents for write ops)
//   rsp_sc_fail   COND_WRITE found no lock, nothing written
//   rsp_err       address out of range, no access performed
module locked_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_LSB = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic                  moe,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_sc_fail,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sc_fail_q, sc_fail_d;
  logic                err_q, err_d;
  logic [DEPTH-1:0]    lock_q, lock_d;

  logic [IDX_W-1:0]    idx;
  logic                addr_err;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr_bits;

  assign idx      = req_addr[ADDR_LSB +: IDX_W];
  // Any address bit above the index field means the word does not exist.
  assign addr_err = (req_addr >> (ADDR_LSB + IDX_W)) != '0;
  assign unused_addr_bits = ^req_addr[ADDR_LSB-1:0];

  be_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (ram_rdata)
  );

  // The whole access (read capture, write, lock update) happens on the
  // acceptance edge; RESP only holds the captured result.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    sc_fail_d = sc_fail_q;
    err_d     = err_q;
    lock_d    = lock_q;
    ram_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_RESP;
          err_d     = addr_err;
          sc_fail_d = 1'b0;
          rdata_d   = addr_err ? '0 : ram_rdata;
          if (!addr_err) begin
            case (req_op)
              OP_LOCK_READ: lock_d[idx] = 1'b1;
              OP_WRITE: begin
                ram_we      = 1'b1;
                lock_d[idx] = 1'b0;
              end
              OP_COND_WRITE: begin
                if (lock_q[idx]) begin
                  ram_we      = 1'b1;
                  lock_d[idx] = 1'b0;
                end else begin
                  sc_fail_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      sc_fail_q <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      sc_fail_q <= sc_fail_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = (rsp_valid && moe) ? rdata_q : '0;
  assign rsp_sc_fail = sc_fail_q;
  assign rsp_err     = err_q;

endmodule
